iomem_initiator: RTL and testbench

Bus master for the PicoSoC iomem interface: the initiating end of the valid/ready/wstrb/addr/wdata/rdata protocol that the GPIO responder serves. Accepts read/write commands on a valid/ready command port, buffers them in a small FIFO, and issues them one at a time on iomem. Returns one response per command, with a timeout error for non-responding slaves. Used by debug/DMA-style agents and as a bench driver for iomem peripherals.

---
 rtl/iomem_initiator.sv | 193 +++++++++++++++++++
 tb/tb_iomem_initiator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_initiator.sv
// iomem bus master: buffers read/write commands in a small FIFO, issues them
// one at a time on the PicoSoC iomem interface and returns one response per
// command, flagging a timeout when the slave never raises iomem_ready.
module iomem_initiator #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        clk_bufg,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  // Last counter value before a timeout fires: valid has then been high TIMEOUT_CYCLES cycles.
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  cmd_t              mem_q [FIFO_DEPTH];
  cmd_t              mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_write_q, rsp_write_d;
  logic              rsp_err_q, rsp_err_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

  logic full, empty, push, pop;
  cmd_t head;

  assign full  = (count_q == FULL_C);
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q];

  // FIFO next state: storage write, pointer advance and occupancy count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Transaction FSM next state: issue, wait for ready or timeout, hold response
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          addr_d  = head.addr;
          wdata_d = head.wdata;
          wstrb_d = head.wstrb;
          valid_d = 1'b1;
          tmo_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // A ready in the last allowed cycle wins over the timeout.
        if (iomem_ready) begin
          valid_d     = 1'b0;
          rsp_rdata_d = (wstrb_q == 4'b0000) ? iomem_rdata : '0;
          rsp_write_d = |wstrb_q;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TO_LAST)) begin
          valid_d     = 1'b0;
          rsp_rdata_d = '0;
          rsp_write_d = |wstrb_q;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          tmo_d = tmo_q + TIMEOUT_W'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage needs no reset: entries are only read once counted valid
  always_ff @(posedge clk_bufg) begin
    mem_q <= mem_d;
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign cmd_ready   = !full;
  assign iomem_valid = valid_q;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign iomem_wstrb = wstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_iomem_initiator.sv
// Scoreboard bench for iomem_initiator: directed commands push expected bus
// transactions and responses into queues; independent monitors pop and compare.
module tb_iomem_initiator;

  logic        clk_bufg = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic        rsp_err;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        busy;

  iomem_initiator #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_W     (8)
  ) dut (
    .clk_bufg   (clk_bufg),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_write  (rsp_write),
    .rsp_err    (rsp_err),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .busy       (busy)
  );

  always #5 clk_bufg = ~clk_bufg;

  int cyc = 0;
  always @(posedge clk_bufg) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Registered slave: raises ready slv_delay edges after seeing valid (0 = never).
  int          slv_delay = 1;
  int          vcnt      = 0;
  logic        rd_mode   = 1'b0;
  logic [31:0] slv_rdata = '0;
  always @(posedge clk_bufg) begin
    if (iomem_valid && !iomem_ready) begin
      vcnt <= vcnt + 1;
      if (slv_delay != 0 && vcnt + 1 == slv_delay) iomem_ready <= 1'b1;
    end else begin
      vcnt        <= 0;
      iomem_ready <= 1'b0;
    end
  end
  assign iomem_rdata = rd_mode ? ~iomem_addr : slv_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        write;
    logic        err;
    int          rise;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hc;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  // Response monitor
  logic        r_cap = 1'b0;
  logic        r_stable;
  rsp_t        r_first;
  int          overlap_cnt = 0;
  always @(negedge clk_bufg) begin
    rsp_t e;
    if (iomem_valid && rsp_valid) overlap_cnt++;
    if (!rsp_valid) r_cap = 1'b0;
    else begin
      if (!r_cap) begin
        r_cap         = 1'b1;
        r_stable      = 1'b1;
        r_first.rdata = rsp_rdata;
        r_first.write = rsp_write;
        r_first.err   = rsp_err;
        r_first.rise  = cyc;
      end else if ({rsp_rdata, rsp_write, rsp_err} !== {r_first.rdata, r_first.write, r_first.err}) begin
        r_stable = 1'b0;
      end
      if (rsp_ready) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_write", 32'(rsp_write), 32'(e.write));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_stable", 32'(r_stable), 1);
          if (e.rise >= 0) check("rsp_latency", r_first.rise, e.rise);
        end
        r_cap = 1'b0;
      end
    end
  end

  // Bus monitor
  logic        b_in = 1'b0;
  logic        b_stable;
  int          b_hc;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_wstrb;
  always @(negedge clk_bufg) begin
    bus_t e;
    if (iomem_valid) begin
      if (!b_in) begin
        b_in = 1'b1; b_hc = 1; b_stable = 1'b1;
        b_addr = iomem_addr; b_wdata = iomem_wdata; b_wstrb = iomem_wstrb;
      end else begin
        b_hc++;
        if ({iomem_addr, iomem_wdata, iomem_wstrb} !== {b_addr, b_wdata, b_wstrb}) b_stable = 1'b0;
      end
    end else if (b_in) begin
      b_in = 1'b0;
      if (resetn) begin
        if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
        else begin
          e = bus_q.pop_front();
          check("bus_addr", b_addr, e.addr);
          check("bus_wdata", b_wdata, e.wdata);
          check("bus_wstrb", 32'(b_wstrb), 32'(e.wstrb));
          check("bus_valid_cycles", b_hc, e.hc);
          check("bus_stable", 32'(b_stable), 1);
        end
      end
    end
  end

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic exp_rsp, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_hc, input int rise_off);
    logic r;
    logic accepted;
    rsp_t er;
    bus_t eb;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    cmd_valid = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 60 && !accepted; i++) begin
      @(negedge clk_bufg);
      r = cmd_ready;
      @(posedge clk_bufg);
      if (r) accepted = 1'b1;
    end
    #1 cmd_valid = 1'b0;
    if (!accepted) begin
      check("cmd_accept_timeout", 0, 1);
      return;
    end
    if (exp_rsp) begin
      er.rdata = exp_rdata;
      er.write = |ws;
      er.err   = exp_err;
      er.rise  = (rise_off < 0) ? -1 : cyc + rise_off;
      rsp_q.push_back(er);
      eb.addr  = a;
      eb.wdata = wd;
      eb.wstrb = ws;
      eb.hc    = exp_hc;
      bus_q.push_back(eb);
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk_bufg);
      #1;
      if (!busy && !rsp_valid && rsp_q.size() == 0 && bus_q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk_bufg);
    #1;
    check("rst_iomem_valid", 32'(iomem_valid), 0);
    check("rst_iomem_addr", iomem_addr, 0);
    check("rst_iomem_wstrb", 32'(iomem_wstrb), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err_write", {30'd0, rsp_err, rsp_write}, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    resetn = 1'b1;
    @(posedge clk_bufg);
    #1;

    // Read with single-cycle registered slave; response exactly 3 edges after accept
    slv_rdata = 32'hABCD_1234;
    push_cmd(32'h0300_0000, 32'hDEAD_BEEF, 4'b0000, 1'b1, 32'hABCD_1234, 1'b0, 2, 3);
    wait_idle();

    // Write: rdata must be zeroed despite the slave driving data
    push_cmd(32'h0300_0000, 32'h00AA_0055, 4'b0101, 1'b1, 32'h0, 1'b0, 2, -1);
    wait_idle();

    // Timeout: slave never ready, then ready in the 8th cycle
    slv_delay = 0;
    slv_rdata = 32'h5555_AAAA;
    push_cmd(32'h0300_0008, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 8, -1);
    wait_idle();
    slv_delay = 7;
    push_cmd(32'h0300_000C, 32'h0, 4'b0000, 1'b1, 32'h5555_AAAA, 1'b0, 8, -1);
    wait_idle();

    // Response held 10 cycles: no new bus request while it waits
    slv_delay = 1;
    rsp_ready = 1'b0;
    push_cmd(32'h0300_0004, 32'h0, 4'b0000, 1'b1, 32'h5555_AAAA, 1'b0, 2, -1);
    push_cmd(32'h0300_0004, 32'h1122_3344, 4'b1111, 1'b1, 32'h0, 1'b0, 2, -1);
    repeat (10) @(posedge clk_bufg);
    #1;
    check("hold_rsp_valid", 32'(rsp_valid), 1);
    check("hold_no_new_req", 32'(iomem_valid), 0);
    check("hold_busy", 32'(busy), 1);
    rsp_ready = 1'b1;
    wait_idle();

    // Backpressure: 5 accepted (1 in flight + 4 buffered), 6th refused until drain
    rsp_ready = 1'b0;
    rd_mode   = 1'b1;
    push_cmd(32'h0300_0010, 32'h0, 4'b0000, 1'b1, 32'hFCFF_FFEF, 1'b0, 2, -1);
    push_cmd(32'h0300_0014, 32'h0, 4'b0000, 1'b1, 32'hFCFF_FFEB, 1'b0, 2, -1);
    push_cmd(32'h0300_0018, 32'h0, 4'b0000, 1'b1, 32'hFCFF_FFE7, 1'b0, 2, -1);
    push_cmd(32'h0300_001C, 32'h0, 4'b0000, 1'b1, 32'hFCFF_FFE3, 1'b0, 2, -1);
    push_cmd(32'h0300_0020, 32'h0, 4'b0000, 1'b1, 32'hFCFF_FFDF, 1'b0, 2, -1);
    cmd_addr  = 32'h0300_0024;
    cmd_wdata = 32'h1234_5678;
    cmd_wstrb = 4'b1111;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_bufg);
      #1;
      check("full_cmd_ready", 32'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    push_cmd(32'h0300_0024, 32'h1234_5678, 4'b1111, 1'b1, 32'h0, 1'b0, 2, -1);
    wait_idle();
    rd_mode = 1'b0;

    // Reset while a request is outstanding: aborted, no response
    slv_delay = 0;
    push_cmd(32'h0300_0030, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 0, -1);
    repeat (3) @(posedge clk_bufg);
    #1;
    check("abort_valid_before", 32'(iomem_valid), 1);
    resetn = 1'b0;
    @(posedge clk_bufg);
    #1;
    check("abort_iomem_valid", 32'(iomem_valid), 0);
    check("abort_rsp_valid", 32'(rsp_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_iomem_addr", iomem_addr, 0);
    @(posedge clk_bufg);
    #1;
    resetn    = 1'b1;
    slv_delay = 1;
    slv_rdata = 32'h1357_9BDF;
    push_cmd(32'h0300_0000, 32'h0, 4'b0000, 1'b1, 32'h1357_9BDF, 1'b0, 2, 3);
    wait_idle();

    check("no_bus_rsp_overlap", overlap_cnt, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
